serial_arbiter: RTL and testbench
=================================

SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data word width in bits; legal range is 2..16.
REQ-002 C  input  1  clock; all state SHALL update on the falling edge of C only.
REQ-003 Rn  input  1  reset, synchronous, active-low; it SHALL be sampled on the falling edge of C.
REQ-004 REQ0  input  1  request from requester 0.
REQ-005 REQ1  input  1  request from requester 1.
REQ-006 D0  input  WIDTH  parallel data of requester 0.
REQ-007 D1  input  WIDTH  parallel data of requester 1.
REQ-008 GNT0  output  1  grant to requester 0, registered, one-cycle pulse.
REQ-009 GNT1  output  1  grant to requester 1, registered, one-cycle pulse.
REQ-010 S  output  1  serial data, MSB first, registered.
REQ-011 BUSY  output  1  high while a word is being shifted out on S.
REQ-012 DONE  output  1  one-cycle pulse marking the end of a transfer.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, SHIFT and END.
REQ-014 Internal state SHALL comprise the state register, a WIDTH-bit shift register SR, a bit counter of ceil(log2(WIDTH)) bits, and a priority bit PRI.
REQ-015 In IDLE with no request, the outputs SHALL be GNT0=GNT1=0, S=0, BUSY=0, DONE=0.
REQ-016 Only IDLE arbitrates; if a request is sampled at falling edge k, then after edge k:
  - the winner's GNTx=1;
  - SR=Dx;
  - S=Dx[WIDTH-1];
  - BUSY=1;
  - counter=0;
  - state=SHIFT.
REQ-017 Arbitration SHALL be as follows:
  - if only one REQ is high, that requester wins;
  - if both are high, the requester selected by PRI wins (PRI=0 selects 0, PRI=1 selects 1).
REQ-018 On every grant, PRI SHALL be set to the index of the non-granted requester (round-robin; the last-served requester gets lowest priority).
REQ-019 A lone requester SHALL be granted even if it was served last.
REQ-020 Dx SHALL be sampled only at the grant edge; later changes to Dx SHALL NOT affect the transfer.
REQ-021 GNTx SHALL be high for exactly one cycle (edge k to edge k+1).
REQ-022 In SHIFT, each falling edge SHALL shift SR left by one, increment the counter, and drive the next lower bit onto S.
  - After edges k+1 .. k+WIDTH-1, S SHALL carry Dx[WIDTH-2] .. Dx[0].
REQ-023 At edge k+WIDTH (counter reaching WIDTH-1 in SHIFT), the block SHALL enter END with DONE=1, BUSY=0 and S=0.
REQ-024 END SHALL unconditionally return to IDLE at the next edge with DONE=0.
  - Requests are ignored in END.
  - The earliest next grant is edge k+WIDTH+2.
REQ-025 REQ0 and REQ1 SHALL be ignored in SHIFT and END.
  - A requester SHALL hold REQ high until it sees its GNT.
  - A REQ dropped before its grant SHALL simply not be served.
REQ-026 GNT0 and GNT1 SHALL never be high in the same cycle.
REQ-027 BUSY and DONE SHALL never be high in the same cycle.
REQ-028 No combinational path SHALL exist from any input to any output.

Reset
REQ-029 Rn=0 at a falling edge SHALL, after that edge, set:
  - state=IDLE, SR=0, counter=0, PRI=0;
  - GNT0=GNT1=S=BUSY=DONE=0.
REQ-030 A reset during SHIFT or END SHALL abort the transfer with no DONE pulse, and no partial word SHALL resume afterwards.
REQ-031 Reset SHALL take priority over every other event sampled at the same edge, including a request.
REQ-032 The first edge with Rn=1 SHALL behave as IDLE (a request sampled there is granted at that edge).

Verification (WIDTH=4)
REQ-033 Rn=0 for 2 edges with REQ0=REQ1=1 -> GNT0=GNT1=S=BUSY=DONE=0 throughout.
REQ-034 Single request: REQ0=1, D0=1011 from IDLE -> expected response:
  - GNT0 pulse for 1 cycle;
  - S=1,0,1,1 on 4 consecutive cycles with BUSY=1;
  - then DONE=1 for 1 cycle;
  - then IDLE.
REQ-035 Simultaneous requests after reset: REQ0=REQ1=1, D0=1100, D1=0011 -> expected response:
  - GNT0 at edge k, S=1,1,0,0, DONE at k+4;
  - GNT1 at edge k+6, S=0,0,1,1, DONE at k+10.
REQ-036 Request during SHIFT: REQ1 raised during requester 0's SHIFT and held -> GNT1 SHALL NOT assert before edge k+6.
REQ-037 Repeated lone requester: REQ1 alone, held through two transfers -> granted at k and k+6, both with correct serial data.
REQ-038 Reset mid-transfer: Rn=0 at the edge after the second bit of D0=1011 -> expected response:
  - BUSY=0, S=0, no DONE;
  - with REQ0=REQ1=1 at the next Rn=1 edge, GNT0 is granted (PRI reset to 0).

Source files
------------

// File: rtl/serial_arbiter.sv
// Two-requester round-robin arbiter that serialises the winner's word MSB first.
// All state moves on the falling edge of C; every output is a register.
module serial_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             Rn,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             S,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, END} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             pri, pri_n;
  logic             gnt0_n, gnt1_n, s_n, busy_n, done_n;
  logic             win0, win1;

  // PRI names the requester that wins a tie; a lone request always wins.
  assign win0 = REQ0 & (~REQ1 | ~pri);
  assign win1 = REQ1 & (~REQ0 |  pri);

  always_ff @(negedge C) begin
    if (!Rn) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (REQ0 | REQ1) state_n = SHIFT;
      SHIFT:   if (cnt == LAST) state_n = END;
      END:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sr_n   = sr;
    cnt_n  = cnt;
    pri_n  = pri;
    gnt0_n = 1'b0;
    gnt1_n = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        if (win0) begin
          gnt0_n = 1'b1;
          sr_n   = D0;
          pri_n  = 1'b1;
          busy_n = 1'b1;
          cnt_n  = '0;
        end else if (win1) begin
          gnt1_n = 1'b1;
          sr_n   = D1;
          pri_n  = 1'b0;
          busy_n = 1'b1;
          cnt_n  = '0;
        end
      end
      SHIFT: begin
        sr_n = {sr[WIDTH-2:0], 1'b0};
        if (cnt == LAST) begin
          done_n = 1'b1;
          cnt_n  = '0;
        end else begin
          busy_n = 1'b1;
          cnt_n  = cnt + CW'(1);
        end
      end
      default: ;
    endcase
    // S always shows the MSB of the word being sent, and is quiet otherwise.
    s_n = busy_n & sr_n[WIDTH-1];
  end

  always_ff @(negedge C) begin
    if (!Rn) begin
      sr   <= '0;
      cnt  <= '0;
      pri  <= 1'b0;
      GNT0 <= 1'b0;
      GNT1 <= 1'b0;
      S    <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      sr   <= sr_n;
      cnt  <= cnt_n;
      pri  <= pri_n;
      GNT0 <= gnt0_n;
      GNT1 <= gnt1_n;
      S    <= s_n;
      BUSY <= busy_n;
      DONE <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_arbiter.sv
// Scoreboard bench for serial_arbiter (WIDTH=4): each driven edge queues the
// expected {GNT0,GNT1,S,BUSY,DONE}; a rising-edge monitor pops and compares.
module tb_serial_arbiter;

  localparam int W = 4;

  logic         C = 1'b0;
  logic         Rn, REQ0, REQ1;
  logic [W-1:0] D0, D1;
  logic         GNT0, GNT1, S, BUSY, DONE;

  typedef struct {
    string      tag;
    logic [4:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_arbiter #(.WIDTH(W)) dut (
    .C(C), .Rn(Rn), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
    .GNT0(GNT0), .GNT1(GNT1), .S(S), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got[4:0], want[4:0]);
    end
  endtask

  function automatic logic [4:0] ev(input logic g0, g1, s, b, d);
    return {g0, g1, s, b, d};
  endfunction

  // Queue the expectation for the coming falling edge, then let that edge pass.
  task automatic step(input string tag, input logic [4:0] e);
    exp_t x;
    x.tag = tag;
    x.val = e;
    exp_q.push_back(x);
    @(negedge C);
    #1;
  endtask

  // Remaining three bits of a word after its grant edge, then the DONE edge.
  task automatic tail(input string tag, input logic [W-1:0] d);
    step({tag, "_b2"}, ev(0, 0, d[2], 1, 0));
    step({tag, "_b1"}, ev(0, 0, d[1], 1, 0));
    step({tag, "_b0"}, ev(0, 0, d[0], 1, 0));
    step({tag, "_done"}, ev(0, 0, 0, 0, 1));
  endtask

  always @(posedge C) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk(x.tag, {27'd0, GNT0, GNT1, S, BUSY, DONE}, {27'd0, x.val});
    end
  end

  initial begin
    Rn = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 4'b1111; D1 = 4'b1111;
    @(posedge C); #1;

    // Reset wins over simultaneous requests.
    step("rst0", ev(0, 0, 0, 0, 0));
    step("rst1", ev(0, 0, 0, 0, 0));

    // Lone request from idle; data changed after the grant must not matter.
    Rn = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    step("idle", ev(0, 0, 0, 0, 0));
    REQ0 = 1'b1; D0 = 4'b1011;
    step("s_gnt", ev(1, 0, 1, 1, 0));
    REQ0 = 1'b0; D0 = 4'b0000;
    tail("s", 4'b1011);
    step("s_idle", ev(0, 0, 0, 0, 0));

    // Reset (PRI back to 0), then a tie: requester 0 first, requester 1 at k+6.
    Rn = 1'b0;
    step("rst2", ev(0, 0, 0, 0, 0));
    Rn = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 4'b1100; D1 = 4'b0011;
    step("t_gnt0", ev(1, 0, 1, 1, 0));
    REQ0 = 1'b0;
    tail("t0", 4'b1100);
    step("t_end", ev(0, 0, 0, 0, 0));
    step("t_gnt1", ev(0, 1, 0, 1, 0));
    REQ1 = 1'b0;
    tail("t1", 4'b0011);
    step("t_idle", ev(0, 0, 0, 0, 0));

    // REQ1 raised during requester 0's shift must wait until k+6.
    REQ0 = 1'b1; D0 = 4'b0110;
    step("m_gnt0", ev(1, 0, 0, 1, 0));
    REQ0 = 1'b0; REQ1 = 1'b1; D1 = 4'b1001;
    tail("m0", 4'b0110);
    step("m_end", ev(0, 0, 0, 0, 0));
    step("m_gnt1", ev(0, 1, 1, 1, 0));

    // Same requester held through a second transfer, new word sampled at k+6.
    D1 = 4'b0101;
    tail("m1", 4'b1001);
    step("r_end", ev(0, 0, 0, 0, 0));
    step("r_gnt1", ev(0, 1, 0, 1, 0));
    D1 = 4'b1110;
    tail("r1", 4'b0101);
    step("r_end2", ev(0, 0, 0, 0, 0));
    step("r_gnt1b", ev(0, 1, 1, 1, 0));
    REQ1 = 1'b0;
    tail("r2", 4'b1110);
    step("r_idle", ev(0, 0, 0, 0, 0));

    // Abort after the second bit; the tie afterwards goes to requester 0.
    REQ0 = 1'b1; D0 = 4'b1011;
    step("a_gnt0", ev(1, 0, 1, 1, 0));
    REQ0 = 1'b0;
    step("a_b2", ev(0, 0, 0, 1, 0));
    Rn = 1'b0;
    step("a_rst", ev(0, 0, 0, 0, 0));
    Rn = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 4'b0111; D1 = 4'b1000;
    step("a_gnt0b", ev(1, 0, 0, 1, 0));
    REQ0 = 1'b0;
    tail("a0", 4'b0111);
    step("a_end", ev(0, 0, 0, 0, 0));
    step("a_gnt1", ev(0, 1, 1, 1, 0));
    REQ1 = 1'b0;
    tail("a1", 4'b1000);
    step("a_idle", ev(0, 0, 0, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge C);
    chk("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
